wb_reg_responder: RTL and testbench

Wishbone responder (slave end) that terminates a registered Wishbone link, e.g. the slave side of an interconnect staging stage. It provides an 8-word, 32-bit register bank:
- Word 0: read-only ID.
- Words 1–6: read/write, byte-selectable.
- Word 7: read-only count of completed accesses.

Responses use a programmable wait-state count, a single-cycle `ack`/`err` pulse, and error termination for decode faults.

---
 rtl/wb_reg_responder.sv | 140 ++++++++++++++
 tb/tb_wb_reg_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_reg_responder.sv
// Wishbone register responder: 8-word bank (ID, six R/W words, access counter)
// with programmable wait states and single-cycle ack/err termination.
module wb_reg_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] ID_VALUE    = 32'h5345_4D31,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wbd_dat_i,
  input  logic [31:0] wbd_adr_i,
  input  logic [3:0]  wbd_sel_i,
  input  logic        wbd_we_i,
  input  logic        wbd_cyc_i,
  input  logic        wbd_stb_i,
  output logic [31:0] wbd_dat_o,
  output logic        wbd_ack_o,
  output logic        wbd_err_o
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam bit         ZeroWait = (WAIT_CYCLES == 0);
  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  wcnt_q;
  logic [31:0] adr_q, wdat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic [31:0] regs_q [8];
  logic [31:0] cnt_q;
  logic        ack_q, err_q;
  logic [31:0] rdat_q;

  logic        req_present;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        req_we;
  logic [2:0]  word;
  logic        dec_err;
  logic [31:0] rd_word;
  logic        resp_go;

  assign req_present = wbd_cyc_i & wbd_stb_i;

  // The zero-wait path decodes the live bus in IDLE; otherwise the captured copy.
  always_comb begin
    if (state_q == StIdle) begin
      req_adr = wbd_adr_i;
      req_dat = wbd_dat_i;
      req_sel = wbd_sel_i;
      req_we  = wbd_we_i;
    end else begin
      req_adr = adr_q;
      req_dat = wdat_q;
      req_sel = sel_q;
      req_we  = we_q;
    end
  end

  always_comb begin
    word    = req_adr[4:2];
    dec_err = (req_adr[31:5] != BASE_ADDR[31:5]) || (req_adr[1:0] != 2'b00) ||
              (req_we && (word == 3'd0 || word == 3'd7));
    case (word)
      3'd0:    rd_word = ID_VALUE;
      3'd7:    rd_word = cnt_q;
      default: rd_word = regs_q[word];
    endcase
    resp_go = req_present &&
              ((state_q == StIdle && ZeroWait) || (state_q == StWait && wcnt_q == 4'd0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rdat_q <= '0;
      case (state_q)
        StIdle: begin
          if (req_present) begin
            adr_q  <= wbd_adr_i;
            wdat_q <= wbd_dat_i;
            sel_q  <= wbd_sel_i;
            we_q   <= wbd_we_i;
            if (!ZeroWait) begin
              wcnt_q  <= WaitLoad;
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (!req_present) begin
            state_q <= StIdle;
          end else if (wcnt_q != 4'd0) begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      // Entering RESP: response, register update and count all land on this edge.
      if (resp_go) begin
        state_q <= StResp;
        if (dec_err) begin
          err_q <= 1'b1;
        end else begin
          ack_q <= 1'b1;
          cnt_q <= cnt_q + 32'd1;
          if (req_we) begin
            for (int b = 0; b < 4; b++) begin
              if (req_sel[b]) regs_q[word][8*b +: 8] <= req_dat[8*b +: 8];
            end
          end else begin
            rdat_q <= rd_word;
          end
        end
      end
    end
  end

  assign wbd_ack_o = ack_q;
  assign wbd_err_o = err_q;
  assign wbd_dat_o = rdat_q;

endmodule

// File: tb/tb_wb_reg_responder.sv
// Scoreboard bench: one zero-wait and one three-wait responder, random and directed accesses.
module tb_wb_reg_responder;

  localparam logic [31:0] Base = 32'h3000_0000;
  localparam logic [31:0] Id   = 32'h5345_4D31;

  typedef struct packed {
    logic        err;
    logic        chkd;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst  [2];
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [31:0] dato [2];
  logic [3:0]  sel  [2];
  logic        we   [2];
  logic        cyc  [2];
  logic        stb  [2];
  logic        ack  [2];
  logic        err  [2];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] mem [2][8];
  logic [31:0] cnt [2];

  always #5 clk = ~clk;

  wb_reg_responder #(.BASE_ADDR(Base), .ID_VALUE(Id), .WAIT_CYCLES(0)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .wbd_dat_i(wdat[0]), .wbd_adr_i(adr[0]),
    .wbd_sel_i(sel[0]), .wbd_we_i(we[0]), .wbd_cyc_i(cyc[0]), .wbd_stb_i(stb[0]),
    .wbd_dat_o(dato[0]), .wbd_ack_o(ack[0]), .wbd_err_o(err[0])
  );

  wb_reg_responder #(.BASE_ADDR(Base), .ID_VALUE(Id), .WAIT_CYCLES(3)) u3 (
    .clk_i(clk), .rst_i(rst[1]), .wbd_dat_i(wdat[1]), .wbd_adr_i(adr[1]),
    .wbd_sel_i(sel[1]), .wbd_we_i(we[1]), .wbd_cyc_i(cyc[1]), .wbd_stb_i(stb[1]),
    .wbd_dat_o(dato[1]), .wbd_ack_o(ack[1]), .wbd_err_o(err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset(input int d);
    for (int i = 0; i < 8; i++) mem[d][i] = '0;
    cnt[d] = '0;
  endfunction

  // Reference behaviour of one access, straight from the register-map rules.
  function automatic exp_t model(input int d, input logic [31:0] a, input logic w,
                                 input logic [31:0] dt, input logic [3:0] s);
    exp_t e;
    int   wi;
    wi = int'(a[4:2]);
    e  = '0;
    if (a[31:5] != Base[31:5] || a[1:0] != 2'b00 || (w && (wi == 0 || wi == 7))) begin
      e.err = 1'b1;
      e.chkd = 1'b1;
      return e;
    end
    if (w) begin
      for (int b = 0; b < 4; b++) if (s[b]) mem[d][wi][8*b +: 8] = dt[8*b +: 8];
    end else begin
      e.chkd = 1'b1;
      e.dat = (wi == 0) ? Id : (wi == 7) ? cnt[d] : mem[d][wi];
    end
    cnt[d] = cnt[d] + 32'd1;
    return e;
  endfunction

  task automatic drive(input int d, input logic [31:0] a, input logic w,
                       input logic [31:0] dt, input logic [3:0] s);
    @(negedge clk);
    adr[d] = a; we[d] = w; wdat[d] = dt; sel[d] = s;
    cyc[d] = 1'b1; stb[d] = 1'b1;
  endtask

  task automatic idle_bus(input int d);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
  endtask

  task automatic access(input int d, input logic [31:0] a, input logic w,
                        input logic [31:0] dt, input logic [3:0] s);
    exp_t e;
    int   n;
    bit   seen;
    e = model(d, a, w, dt, s);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    drive(d, a, w, dt, s);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ack[d] || err[d]) seen = 1'b1;
    end
    idle_bus(d);
    chk("latency", 32'(n), (d == 0) ? 32'd1 : 32'd4);
    @(posedge clk);
  endtask

  task automatic mon(input int d);
    logic        prev;
    logic        a, r;
    logic [31:0] dd;
    exp_t        e;
    int          qs;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev = 1'b0;
        continue;
      end
      a = ack[d]; r = err[d]; dd = dato[d];
      chk("ack_err_exclusive", {31'b0, a & r}, 32'd0);
      chk("single_cycle_pulse", {31'b0, (a | r) & prev}, 32'd0);
      if (a | r) begin
        qs = (d == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
          chk("response_expected", 32'(qs), 32'd1);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk("err_flag", {31'b0, r}, {31'b0, e.err});
          chk("ack_flag", {31'b0, a}, {31'b0, ~e.err});
          if (e.chkd) chk("rdata", dd, e.dat);
        end
      end else begin
        chk("idle_dat_zero", dd, 32'd0);
      end
      prev = a | r;
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic rand_access(input int d);
    logic [31:0] a;
    logic [31:0] x;
    int          r, wi;
    r  = $urandom_range(0, 9);
    wi = $urandom_range(0, 7);
    a  = Base + 32'(wi * 4);
    if (r == 7) a = a + 32'($urandom_range(1, 3));
    if (r == 8) begin
      x = 32'($urandom_range(1, 255)) << 5;
      a = a ^ x;
    end
    if (r == 9) a = $urandom;
    access(d, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; adr[d] = '0; wdat[d] = '0; sel[d] = '0;
      we[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0;
      model_reset(d);
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    mon_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ack", {31'b0, ack[d]}, 32'd0);
      chk("reset_err", {31'b0, err[d]}, 32'd0);
      chk("reset_dat", dato[d], 32'd0);
    end

    // Zero-wait directed: ID, empty word, counter, byte-select write, error cases.
    access(0, 32'h3000_0000, 1'b0, '0, 4'hF);
    access(0, 32'h3000_0004, 1'b0, '0, 4'hF);
    access(0, 32'h3000_001C, 1'b0, '0, 4'hF);
    access(0, 32'h3000_0008, 1'b1, 32'hAABB_CCDD, 4'b0101);
    access(0, 32'h3000_0008, 1'b0, '0, 4'hF);
    access(0, 32'h3000_001C, 1'b0, '0, 4'hF);
    access(0, 32'h3000_0000, 1'b1, 32'h1234_5678, 4'hF);
    access(0, 32'h3000_0020, 1'b0, '0, 4'hF);
    access(0, 32'h3000_0006, 1'b0, '0, 4'hF);
    access(0, 32'h3000_001C, 1'b1, 32'h1, 4'hF);
    access(0, 32'h3000_001C, 1'b0, '0, 4'hF);
    access(0, 32'h3000_000C, 1'b1, 32'hFFFF_FFFF, 4'b0000);
    access(0, 32'h3000_000C, 1'b0, '0, 4'hF);

    // Counter wrap from a forced preload.
    @(negedge clk);
    force u0.cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release u0.cnt_q;
    cnt[0] = 32'hFFFF_FFFF;
    access(0, 32'h3000_0010, 1'b1, 32'hCAFE_F00D, 4'hF);
    access(0, 32'h3000_001C, 1'b0, '0, 4'hF);

    for (int i = 0; i < 80; i++) rand_access(0);

    // Three-wait directed: latency, abort in WAIT, reset in WAIT.
    access(1, 32'h3000_0000, 1'b0, '0, 4'hF);
    drive(1, 32'h3000_0004, 1'b1, 32'hFFFF_FFFF, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    idle_bus(1);
    repeat (6) @(posedge clk);
    access(1, 32'h3000_0004, 1'b0, '0, 4'hF);
    access(1, 32'h3000_001C, 1'b0, '0, 4'hF);
    access(1, 32'h3000_0008, 1'b1, 32'h0BAD_BEEF, 4'hF);
    drive(1, 32'h3000_0008, 1'b1, 32'h1111_2222, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    idle_bus(1);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    model_reset(1);
    repeat (4) @(posedge clk);
    access(1, 32'h3000_0008, 1'b0, '0, 4'hF);
    access(1, 32'h3000_001C, 1'b0, '0, 4'hF);

    for (int i = 0; i < 40; i++) rand_access(1);

    repeat (10) @(posedge clk);
    chk("pending_responses", 32'(q0.size() + q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
